// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins ties; the side that just completed is excluded from the next grant.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRData,
  output logic              IReady,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic [DATA_W-1:0] DRData,
  output logic              DReady,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              StallF,
  output logic              StallM
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;
  logic              iready_q;
  logic              dready_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic done;
  logic pick;
  logic gnt_d;
  logic gnt_i;

  // Arbitration happens in IDLE and on the completion edge of an access.
  assign done  = (state_q != IDLE) && (cnt_q == CNT_W'(WAIT_CYCLES));
  assign pick  = (state_q == IDLE) || done;
  assign gnt_d = pick && DReq && !dready_q && (state_q != DACC);
  assign gnt_i = pick && !gnt_d && IReq && !iready_q && (state_q != IACC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      iready_q <= 1'b0;
      dready_q <= 1'b0;

      if (done) begin
        if (state_q == IACC) begin
          irdata_q <= MemRData;
          iready_q <= 1'b1;
        end else begin
          dready_q <= 1'b1;
          if (!mem_we_q) begin
            drdata_q <= MemRData;
          end
        end
      end

      if (gnt_d) begin
        state_q     <= DACC;
        cnt_q       <= '0;
        mem_en_q    <= 1'b1;
        mem_we_q    <= DWe;
        mem_addr_q  <= DAddr;
        mem_wdata_q <= DWData;
      end else if (gnt_i) begin
        state_q    <= IACC;
        cnt_q      <= '0;
        mem_en_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= IAddr;
      end else if (pick) begin
        state_q  <= IDLE;
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign IRData   = irdata_q;
  assign IReady   = iready_q;
  assign DRData   = drdata_q;
  assign DReady   = dready_q;
  assign MemEn    = mem_en_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;

  // Stalls are combinational so the hazard unit sees them in the request cycle.
  assign StallF = IReq && !iready_q;
  assign StallM = DReq && !dready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT_CYCLES 0, 1, 15) checked against
// a transaction-level model plus directed scenario checks.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst    [3] = '{1'b1, 1'b1, 1'b1};
  logic          ireq   [3] = '{1'b0, 1'b0, 1'b0};
  logic [AW-1:0] iaddr  [3] = '{'0, '0, '0};
  logic          dreq   [3] = '{1'b0, 1'b0, 1'b0};
  logic          dwe    [3] = '{1'b0, 1'b0, 1'b0};
  logic [AW-1:0] daddr  [3] = '{'0, '0, '0};
  logic [DW-1:0] dwdata [3] = '{'0, '0, '0};
  logic [DW-1:0] mrdata [3] = '{'0, '0, '0};

  logic [DW-1:0] irdata [3];
  logic          iready [3];
  logic [DW-1:0] drdata [3];
  logic          dready [3];
  logic          men    [3];
  logic          mwe    [3];
  logic [AW-1:0] maddr  [3];
  logic [DW-1:0] mwdata [3];
  logic          stallf [3];
  logic          stallm [3];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(
      .WAIT_CYCLES(32'((g == 0) ? 0 : ((g == 1) ? 1 : 15))),
      .ADDR_W     (AW),
      .DATA_W     (DW)
    ) u_dut (
      .clk     (clk),
      .reset   (rst[g]),
      .IReq    (ireq[g]),
      .IAddr   (iaddr[g]),
      .IRData  (irdata[g]),
      .IReady  (iready[g]),
      .DReq    (dreq[g]),
      .DWe     (dwe[g]),
      .DAddr   (daddr[g]),
      .DWData  (dwdata[g]),
      .DRData  (drdata[g]),
      .DReady  (dready[g]),
      .MemEn   (men[g]),
      .MemWe   (mwe[g]),
      .MemAddr (maddr[g]),
      .MemWData(mwdata[g]),
      .MemRData(mrdata[g]),
      .StallF  (stallf[g]),
      .StallM  (stallm[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 15);
  endfunction

  // Reference model: owner of the memory (0 none, 1 fetch, 2 data) and cycles left.
  int            m_own  [3] = '{0, 0, 0};
  int            m_left [3] = '{0, 0, 0};
  logic [DW-1:0] e_irdata [3] = '{'0, '0, '0};
  logic [DW-1:0] e_drdata [3] = '{'0, '0, '0};
  logic [DW-1:0] e_wdata  [3] = '{'0, '0, '0};
  logic [AW-1:0] e_addr   [3] = '{'0, '0, '0};
  logic          e_ir [3] = '{1'b0, 1'b0, 1'b0};
  logic          e_dr [3] = '{1'b0, 1'b0, 1'b0};
  logic          e_en [3] = '{1'b0, 1'b0, 1'b0};
  logic          e_we [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    int excl;
    bit pick, nir, ndr, eli, eld;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        m_own[k] = 0; m_left[k] = 0;
        e_irdata[k] = '0; e_drdata[k] = '0; e_wdata[k] = '0; e_addr[k] = '0;
        e_ir[k] = 1'b0; e_dr[k] = 1'b0; e_en[k] = 1'b0; e_we[k] = 1'b0;
      end else begin
        excl = 0; pick = 1'b1; nir = 1'b0; ndr = 1'b0;
        if (m_own[k] != 0) begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) begin
            if (m_own[k] == 1) begin
              e_irdata[k] = mrdata[k];
              nir = 1'b1;
            end else begin
              ndr = 1'b1;
              if (!e_we[k]) e_drdata[k] = mrdata[k];
            end
            excl = m_own[k];
          end else begin
            pick = 1'b0;
          end
        end
        if (pick) begin
          eld = dreq[k] && !e_dr[k] && (excl != 2);
          eli = ireq[k] && !e_ir[k] && (excl != 1);
          if (eld) begin
            m_own[k] = 2; m_left[k] = wc(k) + 1;
            e_en[k] = 1'b1; e_we[k] = dwe[k]; e_addr[k] = daddr[k]; e_wdata[k] = dwdata[k];
          end else if (eli) begin
            m_own[k] = 1; m_left[k] = wc(k) + 1;
            e_en[k] = 1'b1; e_we[k] = 1'b0; e_addr[k] = iaddr[k];
          end else begin
            m_own[k] = 0; e_en[k] = 1'b0; e_we[k] = 1'b0;
          end
        end
        e_ir[k] = nir;
        e_dr[k] = ndr;
      end
    end
  end

  task automatic test_reset;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({iready[k], dready[k], men[k], mwe[k], irdata[k], drdata[k], maddr[k], mwdata[k]} !== 132'd0) begin
        n_fail++;
        $display("FAIL reset_values k=%0d got %h want 0", k,
                 {iready[k], dready[k], men[k], mwe[k], irdata[k], drdata[k], maddr[k], mwdata[k]});
      end
      rst[k] = 1'b0;
    end
    dreq[1] = 1'b1; dwe[1] = 1'b1; daddr[1] = 32'h44; dwdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    n_tests++;
    if ({men[1], mwe[1], maddr[1]} !== {1'b1, 1'b1, 32'h44}) begin
      n_fail++;
      $display("FAIL reset_store_started got %h want %h", {men[1], mwe[1], maddr[1]}, {1'b1, 1'b1, 32'h44});
    end
    rst[1] = 1'b1;
    #1;
    n_tests++;
    if ({men[1], mwe[1], dready[1], maddr[1], mwdata[1], drdata[1], irdata[1]} !== 131'd0) begin
      n_fail++;
      $display("FAIL reset_async_abort got %h want 0",
               {men[1], mwe[1], dready[1], maddr[1], mwdata[1], drdata[1], irdata[1]});
    end
    n_tests++;
    if (stallm[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stallm got %b want 1", stallm[1]);
    end
    dreq[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dready[1], men[1], stallm[1]} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_no_ready got %b want 000", {dready[1], men[1], stallm[1]});
    end
  endtask

  task automatic test_single_fetch;
    ireq[1] = 1'b1; iaddr[1] = 32'h100; mrdata[1] = 32'hE3A00005;
    #1;
    n_tests++;
    if (stallf[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_stall c=0 got %b want 1", stallf[1]);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({men[1], iready[1], stallf[1]} !== {(c == 1 || c == 2), (c == 3), (c < 3)}) begin
        n_fail++;
        $display("FAIL fetch_timing c=%0d got %b want %b", c, {men[1], iready[1], stallf[1]},
                 {(c == 1 || c == 2), (c == 3), (c < 3)});
      end
      if (c == 1) begin
        n_tests++;
        if ({mwe[1], maddr[1]} !== {1'b0, 32'h100}) begin
          n_fail++;
          $display("FAIL fetch_addr got %h want %h", {mwe[1], maddr[1]}, {1'b0, 32'h100});
        end
      end
      if (c == 3) begin
        n_tests++;
        if (irdata[1] !== 32'hE3A00005) begin
          n_fail++;
          $display("FAIL fetch_data got %h want E3A00005", irdata[1]);
        end
        ireq[1] = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous;
    ireq[1] = 1'b1; iaddr[1] = 32'h300;
    dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 32'h200; mrdata[1] = 32'h55;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_tests++;
      if ({men[1], dready[1], iready[1]} !== {(c >= 1 && c <= 4), (c == 3), (c == 5)}) begin
        n_fail++;
        $display("FAIL simul_timing c=%0d got %b want %b", c, {men[1], dready[1], iready[1]},
                 {(c >= 1 && c <= 4), (c == 3), (c == 5)});
      end
      if (c <= 4) begin
        n_tests++;
        if (maddr[1] !== ((c <= 2) ? 32'h200 : 32'h300)) begin
          n_fail++;
          $display("FAIL simul_order c=%0d got %h want %h", c, maddr[1], (c <= 2) ? 32'h200 : 32'h300);
        end
      end
      if (c == 3) begin
        n_tests++;
        if (drdata[1] !== 32'h55) begin
          n_fail++;
          $display("FAIL simul_drdata got %h want 55", drdata[1]);
        end
        dreq[1] = 1'b0; mrdata[1] = 32'h77;
      end
      if (c == 5) begin
        n_tests++;
        if (irdata[1] !== 32'h77) begin
          n_fail++;
          $display("FAIL simul_irdata got %h want 77", irdata[1]);
        end
        ireq[1] = 1'b0;
      end
    end
  endtask

  task automatic test_store;
    dreq[1] = 1'b1; dwe[1] = 1'b1; daddr[1] = 32'h40; dwdata[1] = 32'hDEADBEEF; mrdata[1] = 32'h12345678;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        n_tests++;
        if ({men[1], mwe[1], maddr[1], mwdata[1], dready[1]} !== {1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0}) begin
          n_fail++;
          $display("FAIL store_port c=%0d got %h want %h", c, {men[1], mwe[1], maddr[1], mwdata[1], dready[1]},
                   {1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0});
        end
      end else begin
        n_tests++;
        if ({dready[1], men[1], mwe[1], drdata[1]} !== {(c == 3), 1'b0, 1'b0, 32'h55}) begin
          n_fail++;
          $display("FAIL store_done c=%0d got %h want %h", c, {dready[1], men[1], mwe[1], drdata[1]},
                   {(c == 3), 1'b0, 1'b0, 32'h55});
        end
        dreq[1] = 1'b0;
      end
    end
  endtask

  task automatic test_fairness;
    int last_kind = 0;
    int kind;
    int igap = 0;
    ireq[0] = 1'b1; iaddr[0] = 32'h1000;
    dreq[0] = 1'b1; dwe[0] = 1'b0; daddr[0] = 32'h2000; mrdata[0] = 32'hA0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      n_tests++;
      if ({men[0], maddr[0], iready[0], dready[0], irdata[0], drdata[0]} !==
          {e_en[0], e_addr[0], e_ir[0], e_dr[0], e_irdata[0], e_drdata[0]}) begin
        n_fail++;
        $display("FAIL fair_model c=%0d got %h want %h", c,
                 {men[0], maddr[0], iready[0], dready[0], irdata[0], drdata[0]},
                 {e_en[0], e_addr[0], e_ir[0], e_dr[0], e_irdata[0], e_drdata[0]});
      end
      if (men[0]) begin
        kind = (maddr[0] >= 32'h2000) ? 2 : 1;
        n_tests++;
        if (kind == last_kind || (last_kind == 0 && kind != 2)) begin
          n_fail++;
          $display("FAIL fair_alternate c=%0d got kind %0d want other than %0d", c, kind, last_kind);
        end
        last_kind = kind;
      end
      igap = iready[0] ? 0 : igap + 1;
      n_tests++;
      if (igap > 3) begin
        n_fail++;
        $display("FAIL fair_starve c=%0d got gap %0d want <= 3", c, igap);
      end
      if (iready[0]) iaddr[0] = iaddr[0] + 32'd4;
      if (dready[0]) daddr[0] = daddr[0] + 32'd4;
      mrdata[0] = mrdata[0] + 32'd1;
    end
    dreq[0] = 1'b0;
    while (!iready[0] && igap < 8) begin
      @(negedge clk);
      igap++;
    end
    ireq[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_long_wait;
    int en_cycles = 0;
    int rdy_cycle = -1;
    dreq[2] = 1'b1; dwe[2] = 1'b0; daddr[2] = 32'h80; mrdata[2] = 32'h0BADCAFE;
    for (int c = 1; c <= 25 && rdy_cycle < 0; c++) begin
      @(negedge clk);
      if (men[2]) en_cycles++;
      if (dready[2]) rdy_cycle = c;
    end
    n_tests++;
    if (rdy_cycle != 17 || en_cycles != 16) begin
      n_fail++;
      $display("FAIL long_timing got ready@%0d en=%0d want ready@17 en=16", rdy_cycle, en_cycles);
    end
    n_tests++;
    if (drdata[2] !== 32'h0BADCAFE) begin
      n_fail++;
      $display("FAIL long_data got %h want 0BADCAFE", drdata[2]);
    end
    dreq[2] = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({men[2], dready[2]} !== 2'b00) begin
      n_fail++;
      $display("FAIL long_idle got %b want 00", {men[2], dready[2]});
    end
  endtask

  task automatic test_random;
    int wait_i [3] = '{0, 0, 0};
    int wait_d [3] = '{0, 0, 0};
    bit allow;
    for (int cyc = 0; cyc < 900 && n_fail < 20; cyc++) begin
      @(negedge clk);
      allow = (cyc < 800);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if ({irdata[k], iready[k], drdata[k], dready[k], men[k], mwe[k], maddr[k], mwdata[k]} !==
            {e_irdata[k], e_ir[k], e_drdata[k], e_dr[k], e_en[k], e_we[k], e_addr[k], e_wdata[k]}) begin
          n_fail++;
          $display("FAIL rand_outputs k=%0d cyc=%0d got %h want %h", k, cyc,
                   {irdata[k], iready[k], drdata[k], dready[k], men[k], mwe[k], maddr[k], mwdata[k]},
                   {e_irdata[k], e_ir[k], e_drdata[k], e_dr[k], e_en[k], e_we[k], e_addr[k], e_wdata[k]});
        end
        n_tests++;
        if ({stallf[k], stallm[k]} !== {ireq[k] && !e_ir[k], dreq[k] && !e_dr[k]}) begin
          n_fail++;
          $display("FAIL rand_stall k=%0d cyc=%0d got %b want %b", k, cyc, {stallf[k], stallm[k]},
                   {ireq[k] && !e_ir[k], dreq[k] && !e_dr[k]});
        end
        if (wait_i[k] > 3 * (wc(k) + 1) + 4 || wait_d[k] > 3 * (wc(k) + 1) + 4) begin
          n_tests++;
          n_fail++;
          $display("FAIL rand_bound k=%0d cyc=%0d got waits %0d/%0d want <= %0d", k, cyc,
                   wait_i[k], wait_d[k], 3 * (wc(k) + 1) + 4);
          wait_i[k] = 0; wait_d[k] = 0;
        end
        if (ireq[k]) begin
          if (iready[k]) begin
            wait_i[k] = 0;
            ireq[k] = allow && ($urandom_range(1, 0) == 1);
            iaddr[k] = $urandom;
          end else begin
            wait_i[k]++;
          end
        end else if (allow && $urandom_range(3, 0) == 0) begin
          ireq[k] = 1'b1; iaddr[k] = $urandom;
        end
        if (dreq[k]) begin
          if (dready[k]) begin
            wait_d[k] = 0;
            dreq[k] = 1'b0;
          end else begin
            wait_d[k]++;
          end
        end else if (allow && $urandom_range(2, 0) == 0) begin
          dreq[k] = 1'b1; dwe[k] = ($urandom_range(1, 0) == 1);
          daddr[k] = $urandom; dwdata[k] = $urandom;
        end
        mrdata[k] = $urandom;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_fairness();
    test_long_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
